// File: rtl/cb_config_loader_if.sv
// Word-serial configuration stream between an upstream source and cb_config_loader.
// The source drives valid/data/last; the loader answers with ready.
interface cb_config_loader_if #(
  parameter int W = 8
) ();
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_data;
  logic         cfg_last;

  modport master (
    output cfg_valid,
    output cfg_data,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/cb_config_loader.sv
// Assembles a frame of configuration words in a shadow register and commits it
// atomically to the connection-block bus c; malformed frames are discarded.
module cb_config_loader #(
  parameter int CONF_WIDTH = 88,
  parameter int W          = 8,
  parameter int NWORDS     = (CONF_WIDTH + W - 1) / W,
  parameter int CNT_W      = $clog2(NWORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  cb_config_loader_if.slave     cfg,
  output logic [CONF_WIDTH-1:0] c,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int              SH_W     = NWORDS * W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

  state_t            state;
  logic [SH_W-1:0]   sh;
  logic [SH_W-1:0]   sh_shifted;
  logic [CNT_W-1:0]  cnt;
  logic              xfer;

  assign xfer = cfg.cfg_valid && cfg.cfg_ready;

  // New words enter at the top so the first word ends up in the low bits.
  generate
    if (NWORDS == 1) begin : g_single
      assign sh_shifted = cfg.cfg_data;
    end else begin : g_multi
      assign sh_shifted = {cfg.cfg_data, sh[SH_W-1:W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sh            <= '0;
      cnt           <= '0;
      c             <= '0;
      cfg.cfg_ready <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            sh  <= sh_shifted;
            cnt <= CNT_W'(1);
            if (NWORDS == 1) begin
              if (cfg.cfg_last) begin
                state         <= COMMIT;
                cfg.cfg_ready <= 1'b0;
                busy          <= 1'b1;
              end else begin
                state <= DRAIN;
                err   <= 1'b1;
                busy  <= 1'b1;
              end
            end else if (cfg.cfg_last) begin
              err <= 1'b1;
            end else begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            sh  <= sh_shifted;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              if (cfg.cfg_last) begin
                state         <= COMMIT;
                cfg.cfg_ready <= 1'b0;
              end else begin
                state <= DRAIN;
                err   <= 1'b1;
              end
            end else if (cfg.cfg_last) begin
              state <= IDLE;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end

        // Discard the rest of an over-long frame up to its last word.
        DRAIN: begin
          if (xfer && cfg.cfg_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        COMMIT: begin
          c             <= sh[CONF_WIDTH-1:0];
          done          <= 1'b1;
          err           <= 1'b0;
          state         <= IDLE;
          cfg.cfg_ready <= 1'b1;
          busy          <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          cfg.cfg_ready <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
